// File: rtl/qam_ramp_mapper.sv
// ---------------------------------------------------------------------------
// qam_ramp_mapper
//
// Baseband QAM constellation mapper with a built-in 12-bit ramp source for
// self-test. On every enabled clock the low bits of a 12-bit source word are
// split into I and Q Gray-coded level indices. Each index is mapped to an odd
// amplitude and scaled so that the outer constellation points sit just inside
// the signed 12-bit range.
//
// Ports:
//   i_dclk        sample clock; all state updates on its rising edge
//   i_rst_n       asynchronous, active-low reset
//   i_data[11:0]  external symbol bits, LSB-aligned
//   i_mode[2:0]   modulation select:
//                 0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM, 4 256-QAM,
//                 5 1024-QAM, 6 4096-QAM, 7 reserved (outputs 0)
//   i_en          clock enable; when low, outputs and ramp counter hold
//   i_src_sel     0 = i_data, 1 = internal ramp counter
//   o_inphase     signed two's-complement I amplitude, registered
//   o_quadrature  signed two's-complement Q amplitude, registered
// ---------------------------------------------------------------------------
module qam_ramp_mapper (
    input  logic        i_dclk,
    input  logic        i_rst_n,
    input  logic [11:0] i_data,
    input  logic [2:0]  i_mode,
    input  logic        i_en,
    input  logic        i_src_sel,
    output logic [11:0] o_inphase,
    output logic [11:0] o_quadrature
);

    // Map one axis of m Gray-coded bits (m = 1..6) to a scaled odd amplitude.
    // m = 0 yields a zero mask and a zero scale, so the result is 0.
    function automatic logic [11:0] f_map_axis(input logic [5:0] i_bits,
                                               input logic [2:0] i_m);
        logic [5:0]         v_mask;
        logic [5:0]         v_bits;
        logic [5:0]         v_g;
        logic signed [23:0] v_amp;
        logic signed [23:0] v_scale;
        v_mask = 6'((7'd1 << i_m) - 7'd1);
        v_bits = i_bits & v_mask;
        // Gray to binary: each binary bit is the XOR of all Gray bits at or
        // above it. Bits above m are masked to zero, so starting the prefix
        // XOR at bit 5 is equivalent to starting it at bit m-1.
        v_g[5] = v_bits[5];
        for (int k = 4; k >= 0; k--) begin
            v_g[k] = v_g[k+1] ^ v_bits[k];
        end
        // Odd amplitude 2g - (2^m - 1).
        v_amp = $signed({17'd0, v_g, 1'b0}) - $signed({18'd0, v_mask});
        // Scale = floor(2047 / (2^m - 1)); the peak product is at most 2047,
        // so the low 12 bits of the product are the exact result.
        case (i_m)
            3'd1:    v_scale = 24'sd2047;
            3'd2:    v_scale = 24'sd682;
            3'd3:    v_scale = 24'sd292;
            3'd4:    v_scale = 24'sd136;
            3'd5:    v_scale = 24'sd66;
            3'd6:    v_scale = 24'sd32;
            default: v_scale = 24'sd0;
        endcase
        return 12'(v_amp * v_scale);
    endfunction

    logic [11:0] r_cnt;
    logic [11:0] r_inphase;
    logic [11:0] r_quadrature;

    logic [2:0]  w_m;
    logic        w_bpsk;
    logic        w_rsvd;
    logic [11:0] w_word;
    logic [5:0]  w_i_bits;
    logic [5:0]  w_q_bits;
    logic [11:0] w_i_amp;
    logic [11:0] w_q_amp;

    // Mode decode: bits per axis and the two special cases.
    always_comb begin
        w_m    = 3'd0;
        w_bpsk = 1'b0;
        w_rsvd = 1'b0;
        case (i_mode)
            3'd0: begin
                w_m    = 3'd1;
                w_bpsk = 1'b1;
            end
            3'd7:    w_rsvd = 1'b1;
            default: w_m = i_mode;
        endcase
    end

    // The ramp source uses the pre-increment count, so the value mapped on
    // an edge is the one the counter held just before that edge.
    assign w_word   = i_src_sel ? r_cnt : i_data;

    // Q takes w[m-1:0], I takes w[2m-1:m]; BPSK drives I from w[0] alone.
    assign w_q_bits = w_word[5:0];
    assign w_i_bits = w_bpsk ? w_word[5:0] : 6'(w_word >> w_m);

    assign w_i_amp  = w_rsvd ? 12'd0 : f_map_axis(w_i_bits, w_m);
    assign w_q_amp  = (w_rsvd || w_bpsk) ? 12'd0 : f_map_axis(w_q_bits, w_m);

    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= 12'd0;
            r_inphase    <= 12'd0;
            r_quadrature <= 12'd0;
        end else if (i_en) begin
            // Counter runs on every enabled edge regardless of source select;
            // it wraps 4095 -> 0 naturally.
            r_cnt        <= r_cnt + 12'd1;
            r_inphase    <= w_i_amp;
            r_quadrature <= w_q_amp;
        end
    end

    assign o_inphase    = r_inphase;
    assign o_quadrature = r_quadrature;

endmodule

// File: tb/tb_qam_ramp_mapper.sv
module tb_qam_ramp_mapper;

    logic        i_dclk;
    logic        i_rst_n;
    logic [11:0] i_data;
    logic [2:0]  i_mode;
    logic        i_en;
    logic        i_src_sel;
    logic [11:0] o_inphase;
    logic [11:0] o_quadrature;

    qam_ramp_mapper dut (
        .i_dclk      (i_dclk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_mode      (i_mode),
        .i_en        (i_en),
        .i_src_sel   (i_src_sel),
        .o_inphase   (o_inphase),
        .o_quadrature(o_quadrature)
    );

    initial i_dclk = 1'b0;
    always #5 i_dclk = ~i_dclk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] tb_cnt;          // reference ramp counter
    logic [23:0] sb_q[$];         // expected {I,Q}, pushed when driven
    logic [23:0] exp_v;
    logic [23:0] last_v;

    // Reference axis mapping: search for the level whose Gray code matches.
    function automatic logic [11:0] ref_axis(input logic [5:0] bits, input int m);
        int g, s, a, msk;
        msk = (1 << m) - 1;
        g = 0;
        for (int c = 0; c <= msk; c++)
            if (((c ^ (c >> 1)) & msk) == (int'(bits) & msk)) g = c;
        case (m)
            1: s = 2047;
            2: s = 682;
            3: s = 292;
            4: s = 136;
            5: s = 66;
            default: s = 32;
        endcase
        a = (2 * g - msk) * s;
        return a[11:0];
    endfunction

    function automatic logic [23:0] ref_map(input logic [11:0] w, input logic [2:0] md);
        int m;
        if (md == 3'd7) return 24'd0;
        if (md == 3'd0) return {ref_axis({5'd0, w[0]}, 1), 12'd0};
        m = int'(md);
        return {ref_axis(6'(w >> m), m), ref_axis(w[5:0], m)};
    endfunction

    // Drive one enabled edge; sampling happens 1 time unit after the edge.
    task automatic apply(input logic [11:0] d, input logic [2:0] md, input logic src);
        i_data    = d;
        i_mode    = md;
        i_src_sel = src;
        i_en      = 1'b1;
        @(posedge i_dclk);
        #1;
        tb_cnt = tb_cnt + 12'd1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #7;
        i_rst_n = 1'b1;
        tb_cnt  = 12'd0;
        sb_q.delete();
        @(posedge i_dclk);
        #1;
        // settle with en=0 so this edge does not count
    endtask

    task automatic test_reset();
        i_en = 1'b1; i_src_sel = 1'b1; i_mode = 3'd6; i_data = 12'hABC;
        i_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_inphase, o_quadrature} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_t0 got %h expected 000000", {o_inphase, o_quadrature});
        end
        repeat (3) @(posedge i_dclk);
        #1;
        n_vec++;
        if ({o_inphase, o_quadrature} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_clocked got %h expected 000000", {o_inphase, o_quadrature});
        end
        i_en = 1'b0;
        #2;
        i_rst_n = 1'b1;
        tb_cnt  = 12'd0;
        // First enabled edge after release maps counter 0.
        sb_q.push_back({12'h820, 12'h820});
        apply(12'h000, 3'd6, 1'b1);
        exp_v = sb_q.pop_front();
        n_vec++;
        if ({o_inphase, o_quadrature} !== exp_v) begin
            n_err++;
            $display("FAIL reset_first_count got %h expected %h", {o_inphase, o_quadrature}, exp_v);
        end
        $display("test_reset: first sample %h", {o_inphase, o_quadrature});
    endtask

    task automatic test_qpsk_ramp();
        logic [23:0] pat[4];
        pat[0] = {12'h801, 12'h801};
        pat[1] = {12'h801, 12'h7FF};
        pat[2] = {12'h7FF, 12'h801};
        pat[3] = {12'h7FF, 12'h7FF};
        i_en = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(pat[i % 4]);
            apply(12'hFFF, 3'd1, 1'b1);
            exp_v = sb_q.pop_front();
            n_vec++;
            if ({o_inphase, o_quadrature} !== exp_v) begin
                n_err++;
                $display("FAIL qpsk_ramp[%0d] got %h expected %h", i, {o_inphase, o_quadrature}, exp_v);
            end
            $display("qpsk_ramp[%0d]: I=%h Q=%h", i, o_inphase, o_quadrature);
        end
    endtask

    task automatic test_constants();
        // {data, mode, expected I, expected Q}
        logic [38:0] tbl[10];
        tbl[0] = {12'h00A, 3'd2, 12'h7FE, 12'h7FE};
        tbl[1] = {12'h00F, 3'd2, 12'h2AA, 12'h2AA};
        tbl[2] = {12'h000, 3'd2, 12'h802, 12'h802};
        tbl[3] = {12'hFF5, 3'd2, 12'hD56, 12'hD56};
        tbl[4] = {12'h001, 3'd0, 12'h7FF, 12'h000};
        tbl[5] = {12'h000, 3'd0, 12'h801, 12'h000};
        tbl[6] = {12'hFFE, 3'd0, 12'h801, 12'h000};
        tbl[7] = {12'h5A5, 3'd7, 12'h000, 12'h000};
        tbl[8] = {12'h000, 3'd6, 12'h820, 12'h820};
        tbl[9] = {12'h820, 3'd6, 12'h7E0, 12'h7E0};
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back(tbl[i][23:0]);
            apply(tbl[i][38:27], tbl[i][26:24], 1'b0);
            exp_v = sb_q.pop_front();
            n_vec++;
            if ({o_inphase, o_quadrature} !== exp_v) begin
                n_err++;
                $display("FAIL const[%0d] data=%h mode=%0d got %h expected %h",
                         i, tbl[i][38:27], tbl[i][26:24], {o_inphase, o_quadrature}, exp_v);
            end
            $display("const[%0d]: data=%h mode=%0d I=%h Q=%h", i, tbl[i][38:27],
                     tbl[i][26:24], o_inphase, o_quadrature);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] d;
        logic [2:0]  md;
        logic        src;
        for (int i = 0; i < 40; i++) begin
            d   = 12'($urandom);
            md  = 3'($urandom_range(0, 7));
            src = 1'($urandom_range(0, 1));
            sb_q.push_back(ref_map(src ? tb_cnt : d, md));
            apply(d, md, src);
            exp_v = sb_q.pop_front();
            n_vec++;
            if ({o_inphase, o_quadrature} !== exp_v) begin
                n_err++;
                $display("FAIL b2b[%0d] data=%h mode=%0d src=%0d got %h expected %h",
                         i, d, md, src, {o_inphase, o_quadrature}, exp_v);
            end
            $display("b2b[%0d]: w=%h mode=%0d I=%h Q=%h", i, src ? tb_cnt - 12'd1 : d,
                     md, o_inphase, o_quadrature);
        end
    endtask

    task automatic test_enable();
        sb_q.push_back(ref_map(12'h3C7, 3'd6));
        apply(12'h3C7, 3'd6, 1'b0);
        last_v = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            i_en = 1'b0;
            i_data = 12'($urandom);
            i_mode = 3'($urandom_range(0, 6));
            i_src_sel = 1'($urandom_range(0, 1));
            @(posedge i_dclk);
            #1;
            n_vec++;
            if ({o_inphase, o_quadrature} !== last_v) begin
                n_err++;
                $display("FAIL en_hold[%0d] got %h expected %h", i, {o_inphase, o_quadrature}, last_v);
            end
            $display("en_hold[%0d]: I=%h Q=%h", i, o_inphase, o_quadrature);
        end
        // Counter must not have moved while disabled.
        sb_q.push_back(ref_map(tb_cnt, 3'd6));
        apply(12'h000, 3'd6, 1'b1);
        exp_v = sb_q.pop_front();
        n_vec++;
        if ({o_inphase, o_quadrature} !== exp_v) begin
            n_err++;
            $display("FAIL en_counter_frozen got %h expected %h", {o_inphase, o_quadrature}, exp_v);
        end
        $display("en_counter: I=%h Q=%h", o_inphase, o_quadrature);
    endtask

    task automatic test_wrap();
        i_en = 1'b0;
        do_reset();
        repeat (4095) apply(12'h000, 3'd7, 1'b0);
        sb_q.push_back({12'h2A0, 12'h2A0});   // count 4095
        sb_q.push_back({12'h820, 12'h820});   // wrapped to 0
        for (int i = 0; i < 2; i++) begin
            apply(12'h000, 3'd6, 1'b1);
            exp_v = sb_q.pop_front();
            n_vec++;
            if ({o_inphase, o_quadrature} !== exp_v) begin
                n_err++;
                $display("FAIL wrap[%0d] got %h expected %h", i, {o_inphase, o_quadrature}, exp_v);
            end
            $display("wrap[%0d]: I=%h Q=%h", i, o_inphase, o_quadrature);
        end
    endtask

    task automatic test_midrun_reset();
        apply(12'h000, 3'd6, 1'b1);
        apply(12'h000, 3'd6, 1'b1);
        #3;
        i_rst_n = 1'b0;       // between edges
        #1;
        n_vec++;
        if ({o_inphase, o_quadrature} !== 24'd0) begin
            n_err++;
            $display("FAIL midrun_reset_async got %h expected 000000", {o_inphase, o_quadrature});
        end
        #1;
        i_rst_n = 1'b1;
        tb_cnt  = 12'd0;
        sb_q.delete();
        sb_q.push_back({12'h820, 12'h820});
        apply(12'hFFF, 3'd6, 1'b1);
        exp_v = sb_q.pop_front();
        n_vec++;
        if ({o_inphase, o_quadrature} !== exp_v) begin
            n_err++;
            $display("FAIL midrun_reset_restart got %h expected %h", {o_inphase, o_quadrature}, exp_v);
        end
        $display("midrun_reset: restart I=%h Q=%h", o_inphase, o_quadrature);
    endtask

    initial begin
        tb_cnt = 12'd0;
        test_reset();
        test_qpsk_ramp();
        test_constants();
        test_back_to_back();
        test_enable();
        test_wrap();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

endmodule

// File: doc/qam_ramp_mapper.md
Name: qam_ramp_mapper

Overview:
- Baseband QAM constellation mapper with a built-in 12-bit ramp source for self-test.
- Each enabled clock converts the low bits of a 12-bit word into signed 12-bit in-phase and quadrature amplitudes.
- The modulation order is selected at run time.
- Sits between the bit source (or its own ramp counter) and the DAC/upconversion path.

Parameters:
- none: all widths are fixed at 12 bits; no parameterisation is supported.

Ports:
- dclk  input  1  sample clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data  input  12  external symbol bits, LSB-aligned.
- mode  input  3  modulation select.
- en  input  1  clock enable; when 0, all state holds.
- src_sel  input  1  source select: 0 = data port, 1 = internal ramp counter.
- inphase  output  12  signed two's-complement I amplitude, registered.
- quadrature  output  12  signed two's-complement Q amplitude, registered.

Behaviour:
- Interface: one clock (dclk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, inphase=0, quadrature=0 and ramp counter=0, independent of dclk.
- Ramp counter: 12-bit, increments by 1 on each rising dclk with en=1, regardless of src_sel. Wraps 4095 -> 0 with no flag.
- Source word w: data when src_sel=0; current (pre-increment) counter value when src_sel=1.
- Mode map, with bits per axis m:
  - 0 = BPSK (m=1, I only)
  - 1 = QPSK (m=1)
  - 2 = 16-QAM (m=2)
  - 3 = 64-QAM (m=3)
  - 4 = 256-QAM (m=4)
  - 5 = 1024-QAM (m=5)
  - 6 = 4096-QAM (m=6)
  - 7 = reserved; both outputs 0 while enabled.
- Bit split for QAM modes: Q bits = w[m-1:0]; I bits = w[2m-1:m]. Bits of w above 2m are ignored.
- BPSK: I bit = w[0]; quadrature = 0.
- Per-axis mapping:
  - Bits are Gray code: level index g = gray-to-binary(bits); binary b[k] = XOR of bits[m-1:k].
  - Odd amplitude a = 2g - (2^m - 1).
  - Output = a * S_m, with S_m = floor(2047 / (2^m - 1)).
  - S values: m=1: 2047; m=2: 682; m=3: 292; m=4: 136; m=5: 66; m=6: 32.
  - Peak magnitude is always at most 2047. No saturation logic is needed; the products never exceed 12-bit signed range.
  - Lowest bit pattern (all zeros) gives the most negative amplitude.
- Latency: one clock. Outputs registered on the same edge that consumes w; the counter advances on that same edge.
- mode, data and src_sel are sampled only on enabled edges. Changing them mid-stream takes effect on the next enabled edge, with no glitch and no pipeline flush.
- en=0: outputs and counter hold their values.
- Reset asserted mid-stream: outputs and counter clear immediately. After release, the first enabled edge maps counter value 0 (or current data).
- Implementation constraints:
  - Multiplication by constant S_m may use shift-add or a per-mode lookup of amplitude values.
  - Purely synchronous datapath apart from the reset.

Test Plan:
- Reset: hold rst_n=0, toggle dclk -> inphase=quadrature=0x000 and counter=0. Assert rst_n mid-run -> outputs clear without waiting for a clock edge.
- QPSK ramp (mode=1, src_sel=1, en=1, 8 edges after reset):
  - counter 0 -> I=0x801, Q=0x801
  - counter 1 -> I=0x801, Q=0x7FF
  - counter 2 -> I=0x7FF, Q=0x801
  - counter 3 -> I=0x7FF, Q=0x7FF
  - pattern repeats every 4 samples, one cycle after each count.
- 16-QAM Gray check (mode=2, src_sel=0):
  - data=0x00A -> I=Q=+2046 (0x7FE)
  - data=0x00F -> I=Q=+682 (0x2AA)
  - data=0x000 -> I=Q=-2046 (0x802)
  - data=0xFF5 -> I=Q=-682 (0xD56); upper bits ignored.
- BPSK and reserved:
  - mode=0, data=1 -> I=0x7FF, Q=0
  - mode=0, data=0 -> I=0x801, Q=0
  - mode=7, any data -> I=Q=0
- 4096-QAM extremes (mode=6): data=0x000 -> I=Q=-2016 (0x820); data=0x820 (Gray top level) -> I=Q=+2016 (0x7E0).
- Enable and wrap:
  - en=0 for 5 edges -> outputs and counter frozen.
  - Preset counter near 4095 by running 4095 edges; the next edge maps count 4095 and the counter wraps to 0.
